// File: rtl/mult_pkg.sv
// Shared types for the RV32M multiply issue controller: funct3 encodings,
// controller state encoding and the decoded multiplier control bundle.
package mult_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESP,
    ST_DRAIN
  } ctrl_state_e;

  typedef struct packed {
    logic signed_a;
    logic signed_b;
    logic upper;
  } mult_ctrl_t;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Request/response channel between the RV32M issue stage (master) and the
// multiply issue controller (slave), including the pipeline flush.
interface mult_issue_ctrl_if #(
  parameter int XLEN = mult_pkg::XLEN_DEFAULT
);

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/mult_op_decode.sv
// Combinational RV32M multiply funct3 decoder: produces operand signedness,
// upper-half select, and an illegal flag for the 1xx encodings.
module mult_op_decode
  import mult_pkg::*;
(
  input  logic [2:0] funct3,
  output mult_ctrl_t ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (funct3)
      MUL_F3:    ctrl = '{signed_a: 1'b1, signed_b: 1'b1, upper: 1'b0};
      MULH_F3:   ctrl = '{signed_a: 1'b1, signed_b: 1'b1, upper: 1'b1};
      MULHSU_F3: ctrl = '{signed_a: 1'b1, signed_b: 1'b0, upper: 1'b1};
      MULHU_F3:  ctrl = '{signed_a: 1'b0, signed_b: 1'b0, upper: 1'b1};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Sequencer between RV32M issue and the iterative multiplier: launch, wait with
// a hang watchdog, buffer and return the result. Optional: MULT_RESULT_REUSE_EN.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int WDOG_CYCLES = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mult_issue_ctrl_if.slave  bus,
  output logic              mult_en_o,
  output logic [XLEN-1:0]   mult_op_A_o,
  output logic [XLEN-1:0]   mult_op_B_o,
  output logic              mult_signed_A_o,
  output logic              mult_signed_B_o,
  output logic              mult_upper_o,
  input  logic [XLEN-1:0]   mult_result_i,
  input  logic              mult_done_i
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  ctrl_state_e       state, state_next;
  mult_ctrl_t        dec_ctrl, ctrl_q;
  logic              dec_illegal;
  logic [XLEN-1:0]   op_a_q, op_b_q, resp_data_q;
  logic              resp_err_q;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_expired;

  mult_op_decode u_decode (
    .funct3  (bus.req_funct3),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // >= rather than == so a flush landing on the expiry cycle still drains out
  assign wdog_expired = (wdog_cnt >= WDOG_W'(WDOG_CYCLES - 1));

`ifdef MULT_RESULT_REUSE_EN
  logic            tag_valid, tag_hit;
  logic [XLEN-1:0] tag_rs1, tag_rs2, tag_result;
  logic [2:0]      tag_funct3, funct3_q;

  assign tag_hit = tag_valid && (bus.req_rs1 == tag_rs1) &&
                   (bus.req_rs2 == tag_rs2) && (bus.req_funct3 == tag_funct3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_valid  <= 1'b0;
      tag_rs1    <= '0;
      tag_rs2    <= '0;
      tag_result <= '0;
      tag_funct3 <= '0;
      funct3_q   <= '0;
    end else begin
      if (state == ST_IDLE && state_next == ST_LAUNCH)
        funct3_q <= bus.req_funct3;
      if (bus.flush) begin
        tag_valid <= 1'b0;
      end else if (state == ST_BUSY && state_next == ST_RESP) begin
        tag_valid <= mult_done_i;
        if (mult_done_i) begin
          tag_rs1    <= op_a_q;
          tag_rs2    <= op_b_q;
          tag_funct3 <= funct3_q;
          tag_result <= mult_result_i;
        end
      end else if (state == ST_IDLE && state_next == ST_RESP && dec_illegal) begin
        tag_valid <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!bus.flush && bus.req_valid) begin
          if (dec_illegal)      state_next = ST_RESP;
`ifdef MULT_RESULT_REUSE_EN
          else if (tag_hit)     state_next = ST_RESP;
`endif
          else                  state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_next = bus.flush ? ST_DRAIN : ST_BUSY;
      ST_BUSY: begin
        // a done arriving with the flush has nothing left to drain
        if (bus.flush)         state_next = mult_done_i ? ST_IDLE : ST_DRAIN;
        else if (mult_done_i)  state_next = ST_RESP;
        else if (wdog_expired) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.flush || bus.resp_ready) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mult_done_i || wdog_expired) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      ctrl_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      wdog_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wdog_cnt <= '0;
          if (state_next == ST_LAUNCH) begin
            op_a_q <= bus.req_rs1;
            op_b_q <= bus.req_rs2;
            ctrl_q <= dec_ctrl;
          end else if (state_next == ST_RESP) begin
`ifdef MULT_RESULT_REUSE_EN
            resp_data_q <= dec_illegal ? '0 : tag_result;
`else
            resp_data_q <= '0;
`endif
            resp_err_q  <= dec_illegal;
          end
        end
        ST_BUSY, ST_DRAIN: begin
          wdog_cnt <= wdog_cnt + WDOG_W'(1);
          if (state == ST_BUSY && state_next == ST_RESP) begin
            resp_data_q <= mult_done_i ? mult_result_i : '0;
            resp_err_q  <= !mult_done_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state == ST_IDLE);
  assign bus.resp_valid  = (state == ST_RESP);
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_err    = resp_err_q;
  assign mult_en_o       = (state == ST_LAUNCH);
  assign mult_op_A_o     = op_a_q;
  assign mult_op_B_o     = op_b_q;
  assign mult_signed_A_o = ctrl_q.signed_a;
  assign mult_signed_B_o = ctrl_q.signed_b;
  assign mult_upper_o    = ctrl_q.upper;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a 7-cycle multiplier model; also
// covers the MULT_RESULT_REUSE_EN build when that macro is defined.
module tb_mult_issue_ctrl;

  typedef struct {
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    logic        chk_ctrl;
    logic [2:0]  exp_ctrl;
  } vec_t;

`ifdef MULT_RESULT_REUSE_EN
  localparam int REUSE_LAT = 1;
  localparam int REUSE_EN  = 0;
`else
  localparam int REUSE_LAT = 9;
  localparam int REUSE_EN  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hang = 1'b0;
  logic        mult_en, mult_sa, mult_sb, mult_up, mult_done;
  logic [31:0] mult_a, mult_b, mult_result, model_res;
  logic [5:0]  sr;
  int          en_count = 0;
  int          resp_seen = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  mult_issue_ctrl_if #(.XLEN(32)) bus ();

  mult_issue_ctrl #(.XLEN(32), .WDOG_CYCLES(15)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .mult_en_o       (mult_en),
    .mult_op_A_o     (mult_a),
    .mult_op_B_o     (mult_b),
    .mult_signed_A_o (mult_sa),
    .mult_signed_B_o (mult_sb),
    .mult_upper_o    (mult_up),
    .mult_result_i   (mult_result),
    .mult_done_i     (mult_done)
  );

  function automatic logic [31:0] mulModel(logic [31:0] a, logic [31:0] b,
                                           logic sa, logic sb, logic up);
    logic [63:0] ax, bx, p;
    ax = sa ? {{32{a[31]}}, a} : {32'b0, a};
    bx = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    return up ? p[63:32] : p[31:0];
  endfunction

  // multiplier model: done exactly 7 cycles after the start pulse
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      mult_done <= 1'b0;
      model_res <= '0;
    end else begin
      sr        <= {sr[4:0], mult_en};
      mult_done <= sr[5] && !hang;
      if (mult_en) model_res <= mulModel(mult_a, mult_b, mult_sa, mult_sb, mult_up);
    end
  end

  assign mult_result = mult_done ? model_res : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (mult_en) en_count <= en_count + 1;
    if (bus.resp_valid) resp_seen <= resp_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkVec(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] d, logic e, int lat, int en,
                                 logic chk, logic [2:0] c);
    vec_t v;
    v.funct3 = f3; v.a = a; v.b = b; v.exp_data = d; v.exp_err = e;
    v.exp_lat = lat; v.exp_en = en; v.chk_ctrl = chk; v.exp_ctrl = c;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = v.funct3;
    bus.req_rs1    = v.a;
    bus.req_rs2    = v.b;
    step();
    bus.req_valid  = 1'b0;
  endtask

  task automatic waitResp(output int cyc);
    cyc = 1;
    while (!bus.resp_valid && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic runOp(input vec_t v, input string nm);
    int cyc;
    int en0;
    checkOutput({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    en0 = en_count;
    applyStimulus(v);
    checkOutput({nm, "_en_after_accept"}, 32'(mult_en), 32'(v.exp_en));
    if (v.chk_ctrl) begin
      checkOutput({nm, "_ctrl"}, {29'b0, mult_sa, mult_sb, mult_up}, {29'b0, v.exp_ctrl});
      checkOutput({nm, "_op_a"}, mult_a, v.a);
      checkOutput({nm, "_op_b"}, mult_b, v.b);
    end
    waitResp(cyc);
    checkOutput({nm, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    checkOutput({nm, "_data"}, bus.resp_data, v.exp_data);
    checkOutput({nm, "_err"}, 32'(bus.resp_err), 32'(v.exp_err));
    checkOutput({nm, "_en_pulses"}, 32'(en_count - en0), 32'(v.exp_en));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   en0, rs0, cyc;

    vecs[0] = mkVec(3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 9, 1, 1'b1, 3'b110);
    vecs[1] = mkVec(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 9, 1, 1'b1, 3'b111);
    vecs[2] = mkVec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 9, 1, 1'b1, 3'b001);
    vecs[3] = mkVec(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 9, 1, 1'b1, 3'b101);
    vecs[4] = mkVec(3'b000, 32'h00012345, 32'h10,       32'h00123450, 1'b0, 9, 1, 1'b1, 3'b110);
    vecs[5] = mkVec(3'b100, 32'h7,        32'h3,        32'h0,        1'b1, 1, 0, 1'b0, 3'b000);
    vecs[6] = mkVec(3'b011, 32'h2,        32'h80000000, 32'h1,        1'b0, 9, 1, 1'b1, 3'b001);
    vecs[7] = mkVec(3'b111, 32'h5,        32'h6,        32'h0,        1'b1, 1, 0, 1'b0, 3'b000);

    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;

    // reset state
    #2 rst = 1'b1;
    step();
    step();
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_data", bus.resp_data, 32'd0);
    checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst_mult_en", 32'(mult_en), 32'd0);
    checkOutput("rst_op_a", mult_a, 32'd0);
    checkOutput("rst_ctrl", {29'b0, mult_sa, mult_sb, mult_up}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      runOp(vecs[i], $sformatf("vec%0d", i));
      step();
    end

    // back-pressure: response held for 5 cycles, new request waiting
    bus.resp_ready = 1'b0;
    runOp(mkVec(3'b000, 32'd3, 32'd5, 32'd15, 1'b0, 9, 1, 1'b0, 3'b000), "bp");
    en0 = en_count;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_valid_%0d", k), 32'(bus.resp_valid), 32'd1);
      checkOutput($sformatf("bp_data_%0d", k), bus.resp_data, 32'd15);
      checkOutput($sformatf("bp_ready_%0d", k), 32'(bus.req_ready), 32'd0);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = 3'b000;
      bus.req_rs1    = 32'h10;
      bus.req_rs2    = 32'h20;
      step();
    end
    checkOutput("bp_no_accept", 32'(en_count - en0), 32'd0);
    bus.resp_ready = 1'b1;
    step();
    checkOutput("bp_idle_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("bp_idle_valid", 32'(bus.resp_valid), 32'd0);
    step();
    bus.req_valid = 1'b0;
    checkOutput("bp_next_en", 32'(mult_en), 32'd1);
    waitResp(cyc);
    checkOutput("bp_next_latency", 32'(cyc), 32'd9);
    checkOutput("bp_next_data", bus.resp_data, 32'h200);
    step();

    // flush in the third BUSY cycle
    en0 = en_count;
    rs0 = resp_seen;
    applyStimulus(mkVec(3'b001, 32'h1234, 32'h5678, 32'h0, 1'b0, 9, 1, 1'b0, 3'b000));
    step();
    step();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("fl_drain_ready_%0d", k), 32'(bus.req_ready), 32'd0);
      step();
    end
    checkOutput("fl_ready_after_done", 32'(bus.req_ready), 32'd1);
    checkOutput("fl_no_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("fl_en_pulses", 32'(en_count - en0), 32'd1);
    checkOutput("fl_no_resp", 32'(resp_seen - rs0), 32'd0);

    // watchdog: multiplier never finishes
    hang = 1'b1;
    runOp(mkVec(3'b000, 32'd9, 32'd9, 32'h0, 1'b1, 17, 1, 1'b1, 3'b110), "wdog");
    step();
    hang = 1'b0;

    // asynchronous reset in the middle of BUSY
    rs0 = resp_seen;
    applyStimulus(mkVec(3'b011, 32'd1, 32'd1, 32'h0, 1'b0, 9, 1, 1'b0, 3'b000));
    step();
    step();
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("mid_rst_mult_en", 32'(mult_en), 32'd0);
    checkOutput("mid_rst_op_a", mult_a, 32'd0);
    checkOutput("mid_rst_ctrl", {29'b0, mult_sa, mult_sb, mult_up}, 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) step();
    checkOutput("mid_rst_no_resp", 32'(resp_seen - rs0), 32'd0);
    checkOutput("mid_rst_idle", 32'(bus.req_ready), 32'd1);

    // repeat of an identical op, then a flush forces a fresh launch
    v = mkVec(3'b000, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 9, 1, 1'b0, 3'b000);
    runOp(v, "rep_first");
    step();
    v.exp_lat = REUSE_LAT;
    v.exp_en  = REUSE_EN;
    runOp(v, "rep_second");
    step();
    bus.flush      = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = v.funct3;
    bus.req_rs1    = v.a;
    bus.req_rs2    = v.b;
    en0 = en_count;
    step();
    checkOutput("idle_flush_blocks_en", 32'(mult_en), 32'd0);
    checkOutput("idle_flush_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("idle_flush_no_pulse", 32'(en_count - en0), 32'd0);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    v.exp_lat = 9;
    v.exp_en  = 1;
    runOp(v, "rep_after_flush");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
